// File: rtl/mc_request_arbiter.sv
// mc_request_arbiter
//   Round-robin front end that shares the single memory_controller request
//   port among NUM_CLIENTS client engines. Every accepted request records its
//   client ID in a per-type owner FIFO (one for reads, one for writes). The
//   controller completes each type in order, so popping the matching FIFO on
//   each done pulse tells us which client the completion belongs to.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cl_req_valid/type     per-client request valid and type (1=write, 0=read)
//   cl_req_addr/data      packed per-client address and write data
//   cl_req_grant          one-hot, the request of that client is taken now
//   in_valid, in_request_type/address/data
//                         request toward memory_controller
//   out_busy              controller cannot accept this cycle
//   write_done, read_done, data_out
//                         in-order completions from memory_controller
//   cl_wr_done, cl_rd_valid, cl_rd_data
//                         completions routed back to the issuing client
//   rsp_err               sticky, a done pulse arrived with no owner on record
module mc_request_arbiter #(
  parameter int NUM_CLIENTS  = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 30,
  parameter int MAX_OUTSTAND = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CLIENTS-1:0]            cl_req_valid,
  input  logic [NUM_CLIENTS-1:0]            cl_req_type,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_req_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_req_data,
  output logic [NUM_CLIENTS-1:0]            cl_req_grant,
  output logic                              in_valid,
  output logic                              in_request_type,
  output logic [ADDR_WIDTH-1:0]             in_request_address,
  output logic [DATA_WIDTH-1:0]             in_request_data,
  input  logic                              out_busy,
  input  logic                              write_done,
  input  logic                              read_done,
  input  logic [DATA_WIDTH-1:0]             data_out,
  output logic [NUM_CLIENTS-1:0]            cl_wr_done,
  output logic [NUM_CLIENTS-1:0]            cl_rd_valid,
  output logic [DATA_WIDTH-1:0]             cl_rd_data,
  output logic                              rsp_err
);

  localparam int IDW = $clog2(NUM_CLIENTS);
  localparam int PW  = $clog2(MAX_OUTSTAND);
  localparam int CW  = PW + 1;

  // Index 0 = read owner FIFO, index 1 = write owner FIFO (matches type bit).
  logic [1:0]     fifo_full;
  logic [1:0]     fifo_push;
  logic [1:0]     fifo_pop;
  logic [1:0]     fifo_err;
  logic [1:0]     done_in;
  logic [IDW-1:0] fifo_head [2];

  logic [IDW-1:0] rr_ptr_reg;
  logic [NUM_CLIENTS-1:0] eligible;
  logic           winner_found;
  logic [IDW-1:0] winner_idx;
  logic           winner_type;
  logic           issue;

  logic                  last_type_reg;
  logic [ADDR_WIDTH-1:0] last_addr_reg;
  logic [DATA_WIDTH-1:0] last_data_reg;

  logic [NUM_CLIENTS-1:0] cl_wr_done_reg;
  logic [NUM_CLIENTS-1:0] cl_rd_valid_reg;
  logic [DATA_WIDTH-1:0]  cl_rd_data_reg;
  logic                   rsp_err_reg;

  assign done_in = {write_done, read_done};

  // A client is only eligible if the owner FIFO for its type has room at the
  // start of the cycle; a pop in the same cycle does not open a slot early.
  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      eligible[i] = cl_req_valid[i] && !(cl_req_type[i] ? fifo_full[1] : fifo_full[0]);
    end
  end

  // First eligible client at or above the round-robin pointer, wrapping.
  always_comb begin
    int idx;
    winner_found = 1'b0;
    winner_idx   = '0;
    idx          = 0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      idx = (int'(rr_ptr_reg) + k) % NUM_CLIENTS;
      if (!winner_found && eligible[idx]) begin
        winner_found = 1'b1;
        winner_idx   = IDW'(idx);
      end
    end
  end

  assign winner_type = cl_req_type[winner_idx];
  // Gating with rst_n keeps the request side quiet while reset is held.
  assign issue       = rst_n && winner_found && !out_busy;

  always_comb begin
    cl_req_grant = '0;
    if (issue) begin
      cl_req_grant[winner_idx] = 1'b1;
    end
  end

  // Request fields pass through combinationally on issue and otherwise hold
  // the last issued values.
  assign in_valid           = issue;
  assign in_request_type    = issue ? winner_type : last_type_reg;
  assign in_request_address = issue ? cl_req_addr[winner_idx*ADDR_WIDTH +: ADDR_WIDTH] : last_addr_reg;
  assign in_request_data    = issue ? cl_req_data[winner_idx*DATA_WIDTH +: DATA_WIDTH] : last_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg    <= '0;
      last_type_reg <= 1'b0;
      last_addr_reg <= '0;
      last_data_reg <= '0;
    end else if (issue) begin
      rr_ptr_reg    <= (winner_idx == IDW'(NUM_CLIENTS - 1)) ? '0 : winner_idx + 1'b1;
      last_type_reg <= winner_type;
      last_addr_reg <= cl_req_addr[winner_idx*ADDR_WIDTH +: ADDR_WIDTH];
      last_data_reg <= cl_req_data[winner_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Owner FIFOs. The head is read combinationally because the pop and the
  // routing decision happen on the same edge as the done pulse.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_owner_fifo
      logic [IDW-1:0] mem [MAX_OUTSTAND];
      logic [PW-1:0]  wr_ptr_reg;
      logic [PW-1:0]  rd_ptr_reg;
      logic [CW-1:0]  count_reg;

      assign fifo_full[gi] = (count_reg == CW'(MAX_OUTSTAND));
      assign fifo_push[gi] = issue && (winner_type == 1'(gi));
      assign fifo_pop[gi]  = done_in[gi] && (count_reg != '0);
      assign fifo_err[gi]  = done_in[gi] && (count_reg == '0);
      assign fifo_head[gi] = mem[rd_ptr_reg];

      always_ff @(posedge clk) begin
        if (fifo_push[gi]) begin
          mem[wr_ptr_reg] <= winner_idx;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (fifo_push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (fifo_pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
          case ({fifo_push[gi], fifo_pop[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  // Routed completions, one cycle after the controller's done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cl_wr_done_reg  <= '0;
      cl_rd_valid_reg <= '0;
      cl_rd_data_reg  <= '0;
      rsp_err_reg     <= 1'b0;
    end else begin
      cl_wr_done_reg  <= fifo_pop[1] ? (NUM_CLIENTS'(1) << fifo_head[1]) : '0;
      cl_rd_valid_reg <= fifo_pop[0] ? (NUM_CLIENTS'(1) << fifo_head[0]) : '0;
      if (fifo_pop[0]) begin
        cl_rd_data_reg <= data_out;
      end
      if (|fifo_err) begin
        rsp_err_reg <= 1'b1;
      end
    end
  end

  assign cl_wr_done  = cl_wr_done_reg;
  assign cl_rd_valid = cl_rd_valid_reg;
  assign cl_rd_data  = cl_rd_data_reg;
  assign rsp_err     = rsp_err_reg;

endmodule

// File: tb/tb_mc_request_arbiter.sv
module tb_mc_request_arbiter;

  localparam int NC = 4;
  localparam int DW = 16;
  localparam int AW = 30;
  localparam int MO = 32;

  logic              clk;
  logic              rst_n;
  logic [NC-1:0]     cl_req_valid;
  logic [NC-1:0]     cl_req_type;
  logic [NC*AW-1:0]  cl_req_addr;
  logic [NC*DW-1:0]  cl_req_data;
  logic [NC-1:0]     cl_req_grant;
  logic              in_valid;
  logic              in_request_type;
  logic [AW-1:0]     in_request_address;
  logic [DW-1:0]     in_request_data;
  logic              out_busy;
  logic              write_done;
  logic              read_done;
  logic [DW-1:0]     data_out;
  logic [NC-1:0]     cl_wr_done;
  logic [NC-1:0]     cl_rd_valid;
  logic [DW-1:0]     cl_rd_data;
  logic              rsp_err;

  int n_compared;
  int n_mismatched;

  mc_request_arbiter #(
    .NUM_CLIENTS (NC),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .MAX_OUTSTAND(MO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cl_req_valid      (cl_req_valid),
    .cl_req_type       (cl_req_type),
    .cl_req_addr       (cl_req_addr),
    .cl_req_data       (cl_req_data),
    .cl_req_grant      (cl_req_grant),
    .in_valid          (in_valid),
    .in_request_type   (in_request_type),
    .in_request_address(in_request_address),
    .in_request_data   (in_request_data),
    .out_busy          (out_busy),
    .write_done        (write_done),
    .read_done         (read_done),
    .data_out          (data_out),
    .cl_wr_done        (cl_wr_done),
    .cl_rd_valid       (cl_rd_valid),
    .cl_rd_data        (cl_rd_data),
    .rsp_err           (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int c, input logic [AW-1:0] a);
    cl_req_addr[c*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    cl_req_valid = '0;
    cl_req_type  = '0;
    out_busy     = 1'b0;
    write_done   = 1'b0;
    read_done    = 1'b0;
    data_out     = '0;
    for (int c = 0; c < NC; c++) begin
      set_addr(c, AW'(32'h100 * (c + 1)));
      cl_req_data[c*DW +: DW] = DW'(16'hD000 + c);
    end
    tick();
    tick();
    check_eq("rst_in_valid", {63'd0, in_valid}, 64'd0);
    check_eq("rst_outs", {cl_req_grant, cl_wr_done, cl_rd_valid, cl_rd_data, rsp_err}, 64'd0);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int exp_g[5];
    n_compared   = 0;
    n_mismatched = 0;
    cl_req_addr  = '0;
    cl_req_data  = '0;

    // ---- round robin over four writing clients
    do_reset();
    exp_g = '{0, 1, 2, 3, 0};
    cl_req_valid = 4'b1111;
    cl_req_type  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq($sformatf("rr_grant%0d", k), {60'd0, cl_req_grant}, 64'(1 << exp_g[k]));
      check_eq($sformatf("rr_addr%0d", k), {34'd0, in_request_address}, 64'(32'h100 * (exp_g[k] + 1)));
      tick();
    end
    cl_req_valid = '0;
    write_done   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq($sformatf("wr_done%0d", k), {60'd0, cl_wr_done}, 64'(1 << exp_g[k]));
    end
    write_done = 1'b0;
    tick();
    check_eq("wr_done_idle", {59'd0, cl_wr_done, rsp_err}, 64'd0);

    // ---- single client 2 with the controller busy every other cycle
    cl_req_valid = 4'b0100;
    out_busy = 1'b1; #1;
    check_eq("busy1_grant", {59'd0, in_valid, cl_req_grant}, 64'd0);
    check_eq("busy1_hold", {34'd0, in_request_address}, 64'h100);
    tick();
    out_busy = 1'b0; #1;
    check_eq("free1_grant", {59'd0, in_valid, cl_req_grant}, 64'b10100);
    check_eq("free1_addr", {34'd0, in_request_address}, 64'h300);
    tick();
    out_busy = 1'b1; #1;
    check_eq("busy2_grant", {59'd0, in_valid, cl_req_grant}, 64'd0);
    check_eq("busy2_hold", {34'd0, in_request_address}, 64'h300);
    tick();
    out_busy = 1'b0; #1;
    check_eq("free2_grant", {59'd0, in_valid, cl_req_grant}, 64'b10100);
    tick();
    // pointer now 3: clients 0 and 3 contend, 3 must win
    cl_req_valid = 4'b1001; #1;
    check_eq("ptr3_grant", {60'd0, cl_req_grant}, 64'b1000);
    tick();
    cl_req_valid = '0;
    write_done = 1'b1;
    tick();
    check_eq("drain_a", {60'd0, cl_wr_done}, 64'b0100);
    tick();
    check_eq("drain_b", {60'd0, cl_wr_done}, 64'b0100);
    tick();
    check_eq("drain_c", {60'd0, cl_wr_done}, 64'b1000);
    write_done = 1'b0;

    // ---- in-order read routing
    do_reset();
    cl_req_type = 4'b0000;
    set_addr(1, AW'(32'h10));
    set_addr(3, AW'(32'h20));
    cl_req_valid = 4'b1010; #1;
    check_eq("rd_grant1", {60'd0, cl_req_grant}, 64'b0010);
    check_eq("rd_addr1", {33'd0, in_request_type, in_request_address}, 64'h10);
    tick();
    cl_req_valid = 4'b1000; #1;
    check_eq("rd_grant3", {60'd0, cl_req_grant}, 64'b1000);
    check_eq("rd_addr3", {34'd0, in_request_address}, 64'h20);
    tick();
    cl_req_valid = '0;
    read_done = 1'b1; data_out = 16'hAAAA;
    tick();
    check_eq("rd_rsp1", {44'd0, cl_rd_valid, cl_rd_data}, {44'd0, 4'b0010, 16'hAAAA});
    data_out = 16'h5555;
    tick();
    check_eq("rd_rsp3", {44'd0, cl_rd_valid, cl_rd_data}, {44'd0, 4'b1000, 16'h5555});
    read_done = 1'b0; data_out = 16'h0F0F;
    tick();
    check_eq("rd_hold", {44'd0, cl_rd_valid, cl_rd_data}, {44'd0, 4'b0000, 16'h5555});

    // ---- read FIFO full blocks reads even with a same-cycle pop
    do_reset();
    cl_req_type  = 4'b0010;
    cl_req_valid = 4'b0001;
    for (int k = 0; k < MO; k++) begin
      #1;
      if (k == 0 || k == MO - 1)
        check_eq($sformatf("fill%0d", k), {60'd0, cl_req_grant}, 64'b0001);
      tick();
    end
    #1;
    check_eq("full_block", {59'd0, in_valid, cl_req_grant}, 64'd0);
    tick();
    cl_req_valid = 4'b0011;
    read_done = 1'b1; data_out = 16'hBEEF; #1;
    check_eq("full_pop_grant", {60'd0, cl_req_grant}, 64'b0010);
    check_eq("full_pop_type", {63'd0, in_request_type}, 64'd1);
    tick();
    read_done = 1'b0;
    cl_req_valid = 4'b0001; #1;
    check_eq("after_pop_grant", {60'd0, cl_req_grant}, 64'b0001);
    check_eq("after_pop_rsp", {44'd0, cl_rd_valid, cl_rd_data}, {44'd0, 4'b0001, 16'hBEEF});
    tick();
    cl_req_valid = '0;

    // ---- stray write_done sets sticky error
    do_reset();
    write_done = 1'b1;
    tick();
    write_done = 1'b0;
    check_eq("stray_wr", {59'd0, cl_wr_done, rsp_err}, 64'b00001);
    tick(); tick();
    check_eq("err_sticky", {63'd0, rsp_err}, 64'd1);
    rst_n = 1'b0; #2;
    check_eq("err_clear", {63'd0, rsp_err}, 64'd0);
    rst_n = 1'b1;
    tick();

    // ---- reset with reads in flight drops ownership
    do_reset();
    cl_req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) tick();
    cl_req_valid = '0;
    read_done = 1'b1; data_out = 16'h1234;
    tick();
    read_done = 1'b0;
    check_eq("inflight_rsp", {44'd0, cl_rd_valid, cl_rd_data}, {44'd0, 4'b0100, 16'h1234});
    cl_req_valid = 4'b0100; #1;
    check_eq("pre_rst_valid", {63'd0, in_valid}, 64'd1);
    rst_n = 1'b0; #1;
    check_eq("async_rst_req", {29'd0, in_valid, cl_req_grant, in_request_address}, 64'd0);
    check_eq("async_rst_rsp", {43'd0, cl_rd_valid, cl_rd_data, rsp_err}, 64'd0);
    cl_req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();
    read_done = 1'b1;
    tick();
    read_done = 1'b0;
    check_eq("post_rst_rd", {59'd0, cl_rd_valid, rsp_err}, 64'b00001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
